// File: rtl/clint_device_pkg.sv
// clint_device_pkg: shared definitions for the CLINT device slice.
// Provides the MMIO device bus request/response structs, the CLINT
// register offsets, the default base address and the responder FSM states.
package clint_device_pkg;

  localparam int XLEN        = 64;
  localparam int PADDR_WIDTH = 56;
  localparam int ID_WIDTH    = 4;

  localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

  localparam logic [PADDR_WIDTH-1:0] CLINT_BASE_DEFAULT = 56'h00_0000_0200_0000;

  typedef struct packed {
    logic                   valid;
    logic [ID_WIDTH-1:0]    id;
    logic [PADDR_WIDTH-1:0] paddr;
    logic                   is_write;
    logic [XLEN-1:0]        data;
  } device_req_t;

  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] id;
    logic [XLEN-1:0]     data;
  } device_res_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_e;

  // Word-aligned register offset: the low three bits select bytes inside a
  // 64-bit register and are ignored.
  function automatic logic [15:0] clint_word_ofs(input logic [15:0] ofs);
    return {ofs[15:3], 3'b000};
  endfunction

endpackage

// File: rtl/clint_device_if.sv
// clint_device_if: MMIO device bus between a requester (master) and a
// device (slave).
//   req_i       : request (valid, id, paddr, is_write, data), master -> slave
//   req_ready_o : device can accept a request this cycle, slave -> master
//   res_o       : response (valid, id, data), slave -> master
//   res_ready_i : requester consumes the response, master -> slave
interface clint_device_if;
  import clint_device_pkg::*;

  device_req_t req_i;
  logic        req_ready_o;
  device_res_t res_o;
  logic        res_ready_i;

  modport master (output req_i, output res_ready_i, input req_ready_o, input res_o);
  modport slave  (input req_i, input res_ready_i, output req_ready_o, output res_o);
endinterface

// File: rtl/clint_device_mtime_counter.sv
// clint_mtime_counter: prescaler plus 64-bit machine timer.
//   clk, rst : core clock, synchronous active-high reset
//   wr_en    : load mtime from wr_data this cycle (overrides a tick)
//   wr_data  : value to load
//   mtime    : current timer value (registered)
module clint_mtime_counter #(
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  output logic [63:0] mtime
);

  localparam int unsigned PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MTIME_DIV - 1);

  logic [PW-1:0] presc_r;
  logic          tick_s;

  // With MTIME_DIV=1 the prescaler stays at 0 and every cycle is a tick.
  assign tick_s = (presc_r == PRESC_MAX);

  // Timer and prescaler; a load restarts the prescaler so the next tick
  // comes a full MTIME_DIV cycles after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      mtime   <= 64'd0;
    end else if (wr_en) begin
      presc_r <= '0;
      mtime   <= wr_data;
    end else if (tick_s) begin
      presc_r <= '0;
      mtime   <= mtime + 64'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

endmodule

// File: rtl/clint_device.sv
// clint_device: single-hart CLINT responder on the MMIO device bus.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : device bus slave port (req_i/req_ready_o/res_o/res_ready_i)
//   mtip_o   : machine timer interrupt pending (registered compare)
//   msip_o   : machine software interrupt pending
//   mtime_o  : current mtime for the time CSR
module clint_device
  import clint_device_pkg::*;
#(
  parameter logic [PADDR_WIDTH-1:0] CLINT_BASE = CLINT_BASE_DEFAULT,
  parameter int unsigned            MTIME_DIV  = 1
) (
  input  logic            clk,
  input  logic            rst,
  clint_device_if.slave   bus,
  output logic            mtip_o,
  output logic            msip_o,
  output logic [XLEN-1:0] mtime_o
);

  clint_state_e    state_r;
  logic            req_ready_r;
  device_res_t     res_r;
  logic [XLEN-1:0] mtimecmp_r;
  logic            msip_r;
  logic            mtip_r;
  logic [XLEN-1:0] mtime_s;

  logic            accept_s;
  logic [15:0]     ofs_s;
  logic [XLEN-1:0] rd_data_s;
  logic            wr_msip_s;
  logic            wr_mtimecmp_s;
  logic            wr_mtime_s;
  logic            unused_s;

  assign bus.req_ready_o = req_ready_r;
  assign bus.res_o       = res_r;
  assign mtip_o          = mtip_r;
  assign msip_o          = msip_r;
  assign mtime_o         = mtime_s;

  assign accept_s = bus.req_i.valid && req_ready_r;

  // Offset inside the 64 KiB window; for a 64 KiB-aligned base this is
  // simply paddr[15:0]. Upper address bits are decoded by the PMA.
  assign ofs_s    = clint_word_ofs(bus.req_i.paddr[15:0] - CLINT_BASE[15:0]);
  assign unused_s = ^bus.req_i.paddr[PADDR_WIDTH-1:16];

  assign wr_msip_s     = accept_s && bus.req_i.is_write && (ofs_s == CLINT_MSIP_OFS);
  assign wr_mtimecmp_s = accept_s && bus.req_i.is_write && (ofs_s == CLINT_MTIMECMP_OFS);
  assign wr_mtime_s    = accept_s && bus.req_i.is_write && (ofs_s == CLINT_MTIME_OFS);

  // Read mux; mtime_s is the pre-tick value of the accept cycle.
  always_comb begin
    rd_data_s = 64'd0;
    case (ofs_s)
      CLINT_MSIP_OFS:     rd_data_s = {63'd0, msip_r};
      CLINT_MTIMECMP_OFS: rd_data_s = mtimecmp_r;
      CLINT_MTIME_OFS:    rd_data_s = mtime_s;
      default:            rd_data_s = 64'd0;
    endcase
  end

  clint_mtime_counter #(
    .MTIME_DIV (MTIME_DIV)
  ) u_mtime (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_mtime_s),
    .wr_data (bus.req_i.data),
    .mtime   (mtime_s)
  );

  // Request/response FSM with registered ready and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      res_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_RESP;
            req_ready_r <= 1'b0;
            res_r.valid <= 1'b1;
            res_r.id    <= bus.req_i.id;
            res_r.data  <= bus.req_i.is_write ? 64'd0 : rd_data_s;
          end
        end
        ST_RESP: begin
          if (bus.res_ready_i) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            res_r       <= '0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          res_r       <= '0;
        end
      endcase
    end
  end

  // Software-writable CLINT registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r     <= 1'b0;
    end else begin
      if (wr_mtimecmp_s) begin
        mtimecmp_r <= bus.req_i.data;
      end
      if (wr_msip_s) begin
        msip_r <= bus.req_i.data[0];
      end
    end
  end

  // Timer interrupt compare on the current register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtip_r <= 1'b0;
    end else begin
      mtip_r <= (mtime_s >= mtimecmp_r);
    end
  end

endmodule

// File: tb/tb_clint_device.sv
// tb_clint_device: directed self-checking bench for clint_device.
// Two instances share clock and reset: dut1 with MTIME_DIV=1 and dut4 with
// MTIME_DIV=4. cyc counts non-reset clock edges since the last reset
// release, which equals the expected mtime of dut1 while it is not written.
module tb_clint_device;
  import clint_device_pkg::*;

  localparam logic [PADDR_WIDTH-1:0] BASE = CLINT_BASE_DEFAULT;
  localparam logic [63:0]            ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] cyc = 64'd0;
  int          total = 0;
  int          bad = 0;

  logic        mtip1, msip1, mtip4, msip4;
  logic [63:0] mtime1, mtime4;
  logic [63:0] exp_v;

  clint_device_if if1 ();
  clint_device_if if4 ();

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 64'd0 : cyc + 64'd1;

  clint_device #(.CLINT_BASE(BASE), .MTIME_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .mtip_o(mtip1), .msip_o(msip1), .mtime_o(mtime1)
  );

  clint_device #(.CLINT_BASE(BASE), .MTIME_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .mtip_o(mtip4), .msip_o(msip4), .mtime_o(mtime4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request for one edge (device must be idle).
  task automatic issue(input bit d4, input logic [3:0] id, input logic [15:0] ofs,
                       input bit wr, input logic [63:0] data);
    device_req_t r;
    r.valid    = 1'b1;
    r.id       = id;
    r.paddr    = BASE | {40'd0, ofs};
    r.is_write = wr;
    r.data     = data;
    chk("ready_before_issue", 64'(d4 ? if4.req_ready_o : if1.req_ready_o), 64'd1);
    if (d4) if4.req_i = r; else if1.req_i = r;
    step(1);
    if (d4) if4.req_i.valid = 1'b0; else if1.req_i.valid = 1'b0;
  endtask

  task automatic expect_res(input bit d4, input string tag, input logic [3:0] id,
                            input logic [63:0] data);
    device_res_t r;
    r = d4 ? if4.res_o : if1.res_o;
    chk({tag, "_valid"}, 64'(r.valid), 64'd1);
    chk({tag, "_id"}, 64'(r.id), 64'(id));
    chk({tag, "_data"}, r.data, data);
  endtask

  task automatic consume(input bit d4);
    if (d4) if4.res_ready_i = 1'b1; else if1.res_ready_i = 1'b1;
    step(1);
    if (d4) if4.res_ready_i = 1'b0; else if1.res_ready_i = 1'b0;
    chk("res_dropped", 64'(d4 ? if4.res_o.valid : if1.res_o.valid), 64'd0);
  endtask

  initial begin
    if1.req_i = '0;
    if1.res_ready_i = 1'b0;
    if4.req_i = '0;
    if4.res_ready_i = 1'b0;

    // Reset state
    step(3);
    chk("rst_ready", 64'(if1.req_ready_o), 64'd1);
    chk("rst_res_valid", 64'(if1.res_o.valid), 64'd0);
    chk("rst_mtip", 64'(mtip1), 64'd0);
    chk("rst_msip", 64'(msip1), 64'd0);
    chk("rst_mtime", mtime1, 64'd0);
    chk("rst_mtime4", mtime4, 64'd0);
    rst = 1'b0;

    // mtime counts from reset release; a read returns the accept-cycle value
    step(3);
    chk("mtime_count", mtime1, cyc);
    exp_v = cyc;
    issue(1'b0, 4'd5, CLINT_MTIME_OFS, 1'b0, 64'd0);
    expect_res(1'b0, "rd_mtime", 4'd5, exp_v);
    chk("mtip_idle", 64'(mtip1), 64'd0);
    consume(1'b0);

    // mtimecmp = 20: mtip rises one cycle after mtime shows 20
    issue(1'b0, 4'd1, CLINT_MTIMECMP_OFS, 1'b1, 64'd20);
    expect_res(1'b0, "wr_cmp", 4'd1, 64'd0);
    consume(1'b0);
    for (int i = 0; i < 40 && mtime1 != 64'd20; i++) step(1);
    chk("reach20", mtime1, 64'd20);
    chk("mtip_before", 64'(mtip1), 64'd0);
    step(1);
    chk("mtip_rise", 64'(mtip1), 64'd1);

    // mtimecmp = all ones: mtip falls two cycles after accept
    issue(1'b0, 4'd2, CLINT_MTIMECMP_OFS, 1'b1, ONES);
    expect_res(1'b0, "wr_cmp_ones", 4'd2, 64'd0);
    chk("mtip_hold", 64'(mtip1), 64'd1);
    consume(1'b0);
    chk("mtip_fall", 64'(mtip1), 64'd0);

    // msip write/read
    issue(1'b0, 4'd3, CLINT_MSIP_OFS, 1'b1, 64'hFF);
    chk("msip_set", 64'(msip1), 64'd1);
    expect_res(1'b0, "wr_msip", 4'd3, 64'd0);
    consume(1'b0);
    issue(1'b0, 4'd4, CLINT_MSIP_OFS, 1'b0, 64'd0);
    expect_res(1'b0, "rd_msip", 4'd4, 64'd1);
    consume(1'b0);
    issue(1'b0, 4'd5, CLINT_MSIP_OFS, 1'b1, 64'd0);
    chk("msip_clr", 64'(msip1), 64'd0);
    consume(1'b0);

    // Backpressure with a second request held
    issue(1'b0, 4'd7, CLINT_MTIMECMP_OFS, 1'b0, 64'd0);
    if1.req_i.valid    = 1'b1;
    if1.req_i.id       = 4'd8;
    if1.req_i.paddr    = BASE | {40'd0, CLINT_MSIP_OFS};
    if1.req_i.is_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(if1.res_o.valid), 64'd1);
      chk("bp_id", 64'(if1.res_o.id), 64'd7);
      chk("bp_data", if1.res_o.data, ONES);
      chk("bp_ready", 64'(if1.req_ready_o), 64'd0);
      step(1);
    end
    if1.res_ready_i = 1'b1;
    step(1);
    if1.res_ready_i = 1'b0;
    chk("bp_consumed", 64'(if1.res_o.valid), 64'd0);
    chk("bp_ready_back", 64'(if1.req_ready_o), 64'd1);
    step(1);
    if1.req_i.valid = 1'b0;
    expect_res(1'b0, "bp_second", 4'd8, 64'd0);
    consume(1'b0);

    // Unmapped offsets and ignored low address bits
    issue(1'b0, 4'd3, 16'h1000, 1'b0, 64'd0);
    expect_res(1'b0, "rd_unmapped", 4'd3, 64'd0);
    consume(1'b0);
    issue(1'b0, 4'd6, CLINT_MTIMECMP_OFS, 1'b1, 64'h1234);
    consume(1'b0);
    issue(1'b0, 4'd9, 16'h1000, 1'b1, 64'hDEAD_BEEF);
    expect_res(1'b0, "wr_unmapped", 4'd9, 64'd0);
    consume(1'b0);
    issue(1'b0, 4'd10, 16'h4004, 1'b0, 64'd0);
    expect_res(1'b0, "rd_cmp_lowbits", 4'd10, 64'h1234);
    consume(1'b0);
    issue(1'b0, 4'd11, CLINT_MSIP_OFS, 1'b0, 64'd0);
    expect_res(1'b0, "rd_msip_kept", 4'd11, 64'd0);
    consume(1'b0);

    // Reset during RESP drops the response and restores mtimecmp
    issue(1'b0, 4'd12, CLINT_MTIMECMP_OFS, 1'b0, 64'd0);
    expect_res(1'b0, "rd_before_rst", 4'd12, 64'h1234);
    rst = 1'b1;
    step(1);
    chk("rst_drop_valid", 64'(if1.res_o.valid), 64'd0);
    chk("rst_drop_ready", 64'(if1.req_ready_o), 64'd1);
    rst = 1'b0;
    issue(1'b0, 4'd13, CLINT_MTIMECMP_OFS, 1'b0, 64'd0);
    expect_res(1'b0, "rd_cmp_after_rst", 4'd13, ONES);
    consume(1'b0);

    // MTIME_DIV=4: increments every 4th edge; write on a tick edge wins
    for (int i = 0; i < 8 && cyc[1:0] != 2'd3; i++) step(1);
    chk("div4_phase", 64'(cyc[1:0]), 64'd3);
    chk("div4_count", mtime4, cyc >> 2);
    step(1);
    chk("div4_tick", mtime4, cyc >> 2);
    step(3);
    issue(1'b1, 4'd2, CLINT_MTIME_OFS, 1'b1, 64'h100);
    chk("div4_wr_wins", mtime4, 64'h100);
    expect_res(1'b1, "div4_wr", 4'd2, 64'd0);
    consume(1'b1);
    issue(1'b1, 4'd3, CLINT_MTIME_OFS, 1'b0, 64'd0);
    expect_res(1'b1, "div4_rd", 4'd3, 64'h100);
    consume(1'b1);
    chk("div4_hold3", mtime4, 64'h100);
    step(1);
    chk("div4_next_tick", mtime4, 64'h101);

    // 64-bit wrap and the equality edge of the mtip compare
    issue(1'b0, 4'd6, CLINT_MTIME_OFS, 1'b1, ONES - 64'd1);
    chk("wrap_load", mtime1, ONES - 64'd1);
    consume(1'b0);
    chk("wrap_max", mtime1, ONES);
    chk("wrap_mtip_lo", 64'(mtip1), 64'd0);
    step(1);
    chk("wrap_zero", mtime1, 64'd0);
    chk("wrap_mtip_eq", 64'(mtip1), 64'd1);
    step(1);
    chk("wrap_mtip_off", 64'(mtip1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
